parallel_rx_interface: RTL and testbench



---
 rtl/parallel_rx_interface.sv | 132 +++++++++++++
 tb/tb_parallel_rx_interface.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parallel_rx_interface.sv
// parallel_rx_interface
// Receiver end of the 8-bit parallel frame link. Conditions the link strobe,
// frame flag and byte bus, writes each captured byte to the frame buffer and
// checks the received byte count against the programmed frame length.
//
// Build option: define PARALLEL_RX_SYNC_EN when the link is in a clock domain
// unrelated to CLK. This adds a 2-flop synchronizer plus an edge-detect stage,
// giving a latency of 3. Without it there is a single input register and the
// latency is 1; use that only when the link is driven from CLK.
module parallel_rx_interface #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DATA_IN_CLK,
   input  logic             FLAG_FRAME_IN,
   input  logic [7:0]       DATA_IN,
   input  logic [CNT_W-1:0] FRAME_LENGTH,
   input  logic             ERROR_CLR,
   output logic             WRITE_EN,
   output logic [CNT_W-1:0] WRITE_ADDR,
   output logic [7:0]       WRITE_DATA,
   output logic [CNT_W-1:0] RX_COUNT,
   output logic             FRAME_DONE,
   output logic             FRAME_ERROR
);

`ifdef PARALLEL_RX_SYNC_EN
   localparam int STAGES = 3;
`else
   localparam int STAGES = 1;
`endif

   typedef enum logic [1:0] {IDLE, RECEIVE, DONE, ERROR} state_t;

   state_t           state, nxt;
   logic [9:0]       pipe [STAGES];
   logic             clk_s, flag_s, clk_h, flag_h;
   logic [7:0]       data_s;
   logic             clk_rise, flag_rise;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             frame_start, accept, done_d, err_d;

   // Strobe, flag and byte move through one shared pipeline, so they stay
   // aligned. The pipeline is not reset, so it keeps tracking the pins
   // through reset.
   always_ff @(posedge CLK) begin
      pipe[0] <= {DATA_IN_CLK, FLAG_FRAME_IN, DATA_IN};
      for (int i = 1; i < STAGES; i++)
         pipe[i] <= pipe[i-1];
   end

   assign clk_s  = pipe[STAGES-1][9];
   assign flag_s = pipe[STAGES-1][8];
   assign data_s = pipe[STAGES-1][7:0];

   // Edge-detect history always tracks the last stage, including during
   // reset. A flag that is already high through reset therefore produces no
   // frame start.
   always_ff @(posedge CLK) begin
      clk_h  <= clk_s;
      flag_h <= flag_s;
   end

   assign clk_rise  = clk_s & ~clk_h;
   assign flag_rise = flag_s & ~flag_h;
   assign cnt_inc   = RX_COUNT + CNT_W'(1);

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state logic. A frame start that coincides with ERROR_CLR is
   // discarded.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:
            if (flag_rise && !ERROR_CLR)
               nxt = (FRAME_LENGTH == '0) ? DONE : RECEIVE;
         RECEIVE:
            if (!flag_s)                              nxt = ERROR;  // short frame
            else if (clk_rise && (cnt_inc == len_q))  nxt = DONE;
         DONE:
            if (!flag_s)       nxt = IDLE;
            else if (clk_rise) nxt = ERROR;                         // overrun
         ERROR:
            if (ERROR_CLR)     nxt = IDLE;
         default:              nxt = IDLE;
      endcase
   end

   // Output decode. The result is registered below, so FRAME_DONE rises on
   // the same edge as the final write. FRAME_DONE also holds through IDLE
   // after a good frame.
   always_comb begin
      frame_start = (state == IDLE) && (nxt != IDLE);
      accept      = (state == RECEIVE) && flag_s && clk_rise;
      done_d      = (nxt == DONE) || ((nxt == IDLE) && FRAME_DONE);
      err_d       = (nxt == ERROR);
   end

   // Registered outputs, byte counter and latched frame length
   always_ff @(posedge CLK) begin
      if (RESET) begin
         WRITE_EN    <= 1'b0;
         WRITE_ADDR  <= '0;
         WRITE_DATA  <= '0;
         RX_COUNT    <= '0;
         FRAME_DONE  <= 1'b0;
         FRAME_ERROR <= 1'b0;
         len_q       <= '0;
      end else begin
         WRITE_EN    <= accept;
         FRAME_DONE  <= done_d;
         FRAME_ERROR <= err_d;
         if (frame_start) begin
            len_q    <= FRAME_LENGTH;
            RX_COUNT <= '0;
         end
         if (accept) begin
            WRITE_ADDR <= RX_COUNT;
            WRITE_DATA <= data_s;
            RX_COUNT   <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_parallel_rx_interface.sv
// Scoreboard bench for parallel_rx_interface: the driver pushes expected
// writes, and a monitor pops and compares them on every WRITE_EN.
module tb_parallel_rx_interface;

`ifdef PARALLEL_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        CLK = 0, RESET = 1, DATA_IN_CLK = 0, FLAG_FRAME_IN = 0, ERROR_CLR = 0;
   logic [7:0]  DATA_IN = 0;
   logic [15:0] FRAME_LENGTH = 0;
   logic        WRITE_EN, FRAME_DONE, FRAME_ERROR;
   logic [15:0] WRITE_ADDR, RX_COUNT;
   logic [7:0]  WRITE_DATA;

   parallel_rx_interface #(.CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .DATA_IN_CLK(DATA_IN_CLK),
      .FLAG_FRAME_IN(FLAG_FRAME_IN), .DATA_IN(DATA_IN),
      .FRAME_LENGTH(FRAME_LENGTH), .ERROR_CLR(ERROR_CLR),
      .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
      .RX_COUNT(RX_COUNT), .FRAME_DONE(FRAME_DONE), .FRAME_ERROR(FRAME_ERROR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        done;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_chk = 0, n_fail = 0, cyc = 0, strobe_cyc = 0, n_wr = 0, wr_save;

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write pops one expected entry from the scoreboard
   initial forever begin
      @(posedge CLK);
      #1;
      if (WRITE_EN === 1'b1) begin
         n_wr++;
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", WRITE_ADDR, WRITE_DATA);
         end else begin
            e = q.pop_front();
            chk("wr_addr", 32'(WRITE_ADDR), 32'(e.addr));
            chk("wr_data", 32'(WRITE_DATA), 32'(e.data));
            chk("wr_frame_done", 32'(FRAME_DONE), 32'(e.done));
            chk("wr_latency", 32'(cyc - strobe_cyc), 32'(LAT));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // One strobe: 2 CLK high and 2 CLK low, the minimum legal phases
   task automatic strobe(input logic [7:0] d, input bit exp_wr, input logic [15:0] addr, input bit last);
      exp_t x;
      if (exp_wr) begin
         x.addr = addr; x.data = d; x.done = last;
         q.push_back(x);
      end
      DATA_IN     = d;
      DATA_IN_CLK = 1;
      strobe_cyc  = cyc + 1;
      tick(2);
      DATA_IN_CLK = 0;
      tick(2);
   endtask

   task automatic start_frame(input logic [15:0] len);
      FRAME_LENGTH  = len;
      FLAG_FRAME_IN = 1;
      tick(2);
   endtask

   task automatic end_frame();
      FLAG_FRAME_IN = 0;
      tick(6);
   endtask

   task automatic clr_pulse();
      ERROR_CLR = 1;
      tick(1);
      ERROR_CLR = 0;
      tick(2);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"},    32'(WRITE_EN), 0);
      chk({tag, "_addr"},  32'(WRITE_ADDR), 0);
      chk({tag, "_data"},  32'(WRITE_DATA), 0);
      chk({tag, "_count"}, 32'(RX_COUNT), 0);
      chk({tag, "_done"},  32'(FRAME_DONE), 0);
      chk({tag, "_err"},   32'(FRAME_ERROR), 0);
   endtask

   initial begin
      tick(4);
      chk_zero("reset");
      RESET = 0;
      tick(2);

      // Good frame of 4
      start_frame(4);
      for (int i = 0; i < 4; i++) strobe(8'hA1 + 8'(i), 1, 16'(i), i == 3);
      end_frame();
      chk("t1_done", 32'(FRAME_DONE), 1);
      chk("t1_count", 32'(RX_COUNT), 4);
      chk("t1_err", 32'(FRAME_ERROR), 0);
      chk("t1_q_empty", 32'(q.size()), 0);

      // Short frame: 3 of 5, then clear and a good frame of 5
      start_frame(5);
      for (int i = 0; i < 3; i++) strobe(8'hB1 + 8'(i), 1, 16'(i), 0);
      end_frame();
      chk("t2_err", 32'(FRAME_ERROR), 1);
      chk("t2_done", 32'(FRAME_DONE), 0);
      chk("t2_count", 32'(RX_COUNT), 3);
      clr_pulse();
      chk("t2_err_cleared", 32'(FRAME_ERROR), 0);
      start_frame(5);
      for (int i = 0; i < 5; i++) strobe(8'hC1 + 8'(i), 1, 16'(i), i == 4);
      end_frame();
      chk("t2b_done", 32'(FRAME_DONE), 1);
      chk("t2b_count", 32'(RX_COUNT), 5);
      chk("t2b_q_empty", 32'(q.size()), 0);

      // Overrun: 3 strobes on a frame of 2; clear while the flag is still high
      start_frame(2);
      strobe(8'hD1, 1, 0, 0);
      strobe(8'hD2, 1, 1, 1);
      strobe(8'hD3, 0, 0, 0);
      tick(2);
      chk("t3_err", 32'(FRAME_ERROR), 1);
      chk("t3_done", 32'(FRAME_DONE), 0);
      chk("t3_count", 32'(RX_COUNT), 2);
      clr_pulse();
      chk("t3_err_cleared", 32'(FRAME_ERROR), 0);
      strobe(8'hD4, 0, 0, 0);  // flag high but no fresh rise: no frame
      chk("t3_count_hold", 32'(RX_COUNT), 2);
      end_frame();
      chk("t3_idle_done", 32'(FRAME_DONE), 0);
      chk("t3_q_empty", 32'(q.size()), 0);

      // Zero-length frame
      wr_save = n_wr;
      start_frame(0);
      tick(4);
      end_frame();
      chk("t4_done", 32'(FRAME_DONE), 1);
      chk("t4_count", 32'(RX_COUNT), 0);
      chk("t4_no_writes", 32'(n_wr - wr_save), 0);

      // Reset mid-frame: 2 of 6 bytes, reset with flag high
      start_frame(6);
      strobe(8'hE1, 1, 0, 0);
      strobe(8'hE2, 1, 1, 0);
      RESET = 1;
      tick(2);
      RESET = 0;
      chk_zero("t5_rst");
      strobe(8'hE3, 0, 0, 0);
      strobe(8'hE4, 0, 0, 0);
      chk("t5_count_after", 32'(RX_COUNT), 0);
      chk("t5_addr_after", 32'(WRITE_ADDR), 0);
      end_frame();
      start_frame(3);
      for (int i = 0; i < 3; i++) strobe(8'hF1 + 8'(i), 1, 16'(i), i == 2);
      end_frame();
      chk("t5_done", 32'(FRAME_DONE), 1);
      chk("t5_count", 32'(RX_COUNT), 3);
      chk("t5_q_empty", 32'(q.size()), 0);

      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
